comb_sweep_seq: RTL and testbench
=================================

// Module: comb_sweep_seq
// PURPOSE
//  Upstream stimulus sequencer and response capture for the 4-input, sel-controlled
//  combinational stage (comb_str2-class). On start it drives {A,B,C,D} through 0..15
//  with sel=0, then through 0..15 with sel=1. It samples y once per pattern and packs
//  the 32 samples into a result word. It replaces the hand-written #delay stimulus loop
//  with synthesizable, clocked hardware.
// PARAMETERS
//  STEP_CYCLES  10  cycles each pattern is held before y is sampled (legal: >=1)
//  AUTO_RESTART 0   1: re-enter the sweep the cycle after done, without a new start
// PORTS
//  clk     in   1   rising-edge clock
//  rst_n   in   1   asynchronous, active-low reset
//  start   in   1   begin sweep; sampled only in IDLE
//  y       in   1   output of the combinational stage
//  A,B,C,D out  1   stimulus; {A,B,C,D} = pattern index idx[3:0], A = MSB
//  sel     out  1   stimulus select; 0 = first pass, 1 = second pass
//  busy    out  1   high while the sweep is in progress
//  done    out  1   one-cycle pulse when the sweep completes
//  result  out  32  result[{sel,idx}] = y sampled for that pattern
//  pause   in   1   only present with SWEEP_PAUSE_EN (see CONFIGURATION)
// BEHAVIOUR
//  - One clock, clk. Reset is asynchronous and active-low on rst_n.
//  - Reset (async, any time, including mid-sweep): state=IDLE; A..D, sel, busy, done = 0;
//    result = 0; step counter cnt = 0. Outputs stay low until a new start.
//  - Registered outputs only; there is no combinational path from y or start to any output.
//  - IDLE: outputs {A,B,C,D} = 0 and sel = 0. If start=1 at edge k:
//    - state becomes DRIVE;
//    - busy=1 from edge k;
//    - idx=0, sel=0, cnt=0;
//    - result cleared to 0 at edge k.
//  - DRIVE:
//    - cnt increments each cycle.
//    - At the edge where cnt==STEP_CYCLES-1:
//      - result[{sel,idx}] <= y;
//      - cnt <= 0;
//      - advance the pattern.
//    - Advance rules:
//      - idx<15: idx+1.
//      - idx==15, sel==0: sel<=1, idx<=0.
//      - idx==15, sel==1: state goes to DONE.
//  - DONE:
//    - done=1 and busy=0 for exactly one cycle;
//    - {A,B,C,D} and sel return to 0;
//    - next state is IDLE, or DRIVE (with result cleared) when AUTO_RESTART=1.
//  - Latency: the first sample is at edge k+STEP_CYCLES. The last sample is at edge
//    k+32*STEP_CYCLES, which is also the edge where done rises.
//  - result holds its value from done until the next accepted start (or reset).
//  - start while busy or in DONE: ignored, with no effect on counters.
//  - STEP_CYCLES=1: a new pattern every cycle; the sample is taken on the pattern's only cycle.
//  - cnt width = $clog2(STEP_CYCLES+1). idx is 4 bits and is never allowed to wrap silently.
// CONFIGURATION
//  SWEEP_PAUSE_EN defined:
//    - adds input port pause.
//    - While pause=1 in DRIVE: cnt, idx and sel are frozen, no sample is taken, and the
//      outputs are held.
//    - pause is ignored in IDLE and DONE.
//  SWEEP_PAUSE_EN undefined:
//    - the port is absent; behaviour is identical to pause tied to 0.
// TESTING
//  1 y wired to A, STEP_CYCLES=10, start pulse -> result=32'hFF00FF00; done 320 cycles after start
//  2 y wired to D, STEP_CYCLES=1 -> result=32'hAAAAAAAA; the 32 patterns appear on consecutive cycles
//  3 y wired to sel -> result=32'hFFFF0000; sel rises after the 16th sample
//  4 rst_n low at cycle 50 mid-sweep -> all outputs 0 immediately; a restart then gives a full result
//  5 start re-pulsed while busy -> ignored; done timing and result unchanged vs scenario 1
//  6 SWEEP_PAUSE_EN, pause=1 for 7 cycles mid-sweep -> done delayed 7 cycles, result unchanged

Source files
------------

// File: rtl/comb_sweep_seq.sv
// Clocked stimulus sequencer and response capture for a 4-input, sel-controlled comb stage.
// Optional `define SWEEP_PAUSE_EN adds a pause input that freezes the sweep while in DRIVE.
module comb_sweep_seq #(
  parameter int unsigned STEP_CYCLES  = 10,
  parameter bit          AUTO_RESTART = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef SWEEP_PAUSE_EN
  input  logic        pause,
`endif
  input  logic        start,
  input  logic        y,
  output logic        A,
  output logic        B,
  output logic        C,
  output logic        D,
  output logic        sel,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  localparam int unsigned     CntW    = $clog2(STEP_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(STEP_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StDone
  } state_e;

  state_e          r_state, w_state_nxt;
  logic [3:0]      r_idx, w_idx_nxt;
  logic            r_sel, w_sel_nxt;
  logic [CntW-1:0] r_cnt, w_cnt_nxt;
  logic            r_busy, w_busy_nxt;
  logic            r_done, w_done_nxt;
  logic [31:0]     r_result, w_result_nxt;
  logic            w_pause;

`ifdef SWEEP_PAUSE_EN
  assign w_pause = pause;
`else
  assign w_pause = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_idx    <= 4'h0;
      r_sel    <= 1'b0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= 32'h0;
    end else begin
      r_state  <= w_state_nxt;
      r_idx    <= w_idx_nxt;
      r_sel    <= w_sel_nxt;
      r_cnt    <= w_cnt_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_result <= w_result_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_sel_nxt    = r_sel;
    w_cnt_nxt    = r_cnt;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    w_result_nxt = r_result;

    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_state_nxt  = StDrive;
          w_busy_nxt   = 1'b1;
          w_idx_nxt    = 4'h0;
          w_sel_nxt    = 1'b0;
          w_cnt_nxt    = '0;
          w_result_nxt = 32'h0;
        end
      end

      StDrive: begin
        if (!w_pause) begin
          if (r_cnt == CntLast) begin
            // Sample on the last held cycle of the pattern, then advance.
            w_result_nxt[{r_sel, r_idx}] = y;
            w_cnt_nxt                    = '0;
            if (r_idx != 4'hF) begin
              w_idx_nxt = r_idx + 4'h1;
            end else if (!r_sel) begin
              w_sel_nxt = 1'b1;
              w_idx_nxt = 4'h0;
            end else begin
              w_state_nxt = StDone;
              w_busy_nxt  = 1'b0;
              w_done_nxt  = 1'b1;
              w_idx_nxt   = 4'h0;
              w_sel_nxt   = 1'b0;
            end
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end

      StDone: begin
        if (AUTO_RESTART) begin
          w_state_nxt  = StDrive;
          w_busy_nxt   = 1'b1;
          w_idx_nxt    = 4'h0;
          w_sel_nxt    = 1'b0;
          w_cnt_nxt    = '0;
          w_result_nxt = 32'h0;
        end else begin
          w_state_nxt = StIdle;
        end
      end

      default: begin
        w_state_nxt = StIdle;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  assign A      = r_idx[3];
  assign B      = r_idx[2];
  assign C      = r_idx[1];
  assign D      = r_idx[0];
  assign sel    = r_sel;
  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

endmodule

// File: tb/tb_comb_sweep_seq.sv
// Directed bench for comb_sweep_seq: one instance at STEP_CYCLES=10, one at STEP_CYCLES=1.
module tb_comb_sweep_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start0, start1, pause0;
  logic [1:0]  ymode0, ymode1;
  logic        y0, y1;
  logic        a0, b0, c0, d0, sel0, busy0, done0;
  logic        a1, b1, c1, d1, sel1, busy1, done1;
  logic [31:0] res0, res1;
  logic        dsel;

  int n_tests = 0;
  int n_fail  = 0;
  int lat, fs;

  // y source: 0 = A, 1 = D, 2 = sel
  always_comb begin
    case (ymode0)
      2'd0:    y0 = a0;
      2'd1:    y0 = d0;
      default: y0 = sel0;
    endcase
    case (ymode1)
      2'd0:    y1 = a1;
      2'd1:    y1 = d1;
      default: y1 = sel1;
    endcase
  end

  comb_sweep_seq #(.STEP_CYCLES(10), .AUTO_RESTART(1'b0)) u_dut0 (
`ifdef SWEEP_PAUSE_EN
    .pause  (pause0),
`endif
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start0),
    .y      (y0),
    .A      (a0),
    .B      (b0),
    .C      (c0),
    .D      (d0),
    .sel    (sel0),
    .busy   (busy0),
    .done   (done0),
    .result (res0)
  );

  comb_sweep_seq #(.STEP_CYCLES(1), .AUTO_RESTART(1'b0)) u_dut1 (
`ifdef SWEEP_PAUSE_EN
    .pause  (1'b0),
`endif
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start1),
    .y      (y1),
    .A      (a1),
    .B      (b1),
    .C      (c1),
    .D      (d1),
    .sel    (sel1),
    .busy   (busy1),
    .done   (done1),
    .result (res1)
  );

  logic        cur_done, cur_busy, cur_sel;
  logic [4:0]  cur_pat;
  logic [31:0] cur_res;
  assign cur_done = dsel ? done1 : done0;
  assign cur_busy = dsel ? busy1 : busy0;
  assign cur_sel  = dsel ? sel1 : sel0;
  assign cur_pat  = dsel ? {sel1, a1, b1, c1, d1} : {sel0, a0, b0, c0, d0};
  assign cur_res  = dsel ? res1 : res0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_start(input logic which, input logic v);
    if (which) start1 = v;
    else       start0 = v;
  endtask

  // Pulses start, then counts negedges until done; lat = cycles from the start edge to done.
  task automatic run_sweep(input logic which, input bit chk_pat, input int repulse_at,
                           input int pause_at, input int pause_len,
                           output int lat_o, output int first_sel_o);
    dsel = which;
    lat_o = -1;
    first_sel_o = -1;
    @(negedge clk);
    set_start(which, 1'b1);
    for (int n = 1; n <= 1000; n++) begin
      @(negedge clk);
      if (n == 1) begin
        set_start(which, 1'b0);
        chk("busy_at_start", {31'h0, cur_busy}, 32'h1);
        chk("result_cleared", cur_res, 32'h0);
      end
      if (repulse_at > 0 && n == repulse_at)     set_start(which, 1'b1);
      if (repulse_at > 0 && n == repulse_at + 3) set_start(which, 1'b0);
      if (pause_len > 0 && n == pause_at)             pause0 = 1'b1;
      if (pause_len > 0 && n == pause_at + pause_len) pause0 = 1'b0;
      if (chk_pat && n <= 32) chk("pattern_seq", {27'h0, cur_pat}, n - 1);
      if (first_sel_o < 0 && cur_sel) first_sel_o = n;
      if (cur_done) begin
        lat_o = n - 1;
        break;
      end
    end
    set_start(which, 1'b0);
    pause0 = 1'b0;
    @(negedge clk);
    chk("done_one_cycle", {31'h0, cur_done}, 32'h0);
    chk("busy_after_done", {31'h0, cur_busy}, 32'h0);
    chk("pattern_after_done", {27'h0, cur_pat}, 32'h0);
  endtask

  initial begin
    rst_n  = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    pause0 = 1'b0;
    ymode0 = 2'd0;
    ymode1 = 2'd1;
    dsel   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_result0", res0, 32'h0);
    chk("rst_ctrl0", {25'h0, busy0, done0, sel0, a0, b0, c0, d0}, 32'h0);
    chk("rst_ctrl1", {25'h0, busy1, done1, sel1, a1, b1, c1, d1}, 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_no_start", {30'h0, busy0, busy1}, 32'h0);

    // y = A, step 10
    ymode0 = 2'd0;
    run_sweep(1'b0, 1'b0, 0, 0, 0, lat, fs);
    chk("s1_latency", lat, 320);
    chk("s1_result", res0, 32'hFF00FF00);
    repeat (5) @(negedge clk);
    chk("s1_result_held", res0, 32'hFF00FF00);

    // y = D, step 1
    ymode1 = 2'd1;
    run_sweep(1'b1, 1'b1, 0, 0, 0, lat, fs);
    chk("s2_latency", lat, 32);
    chk("s2_result", res1, 32'hAAAAAAAA);

    // y = sel, step 10
    ymode0 = 2'd2;
    run_sweep(1'b0, 1'b0, 0, 0, 0, lat, fs);
    chk("s3_sel_rise", fs, 161);
    chk("s3_result", res0, 32'hFFFF0000);

    // Reset mid-sweep, then a clean restart
    ymode0 = 2'd1;
    dsel   = 1'b0;
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (49) @(negedge clk);
    chk("s4_mid_result", res0, 32'h0000000A);
    chk("s4_mid_busy", {31'h0, busy0}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("s4_rst_result", res0, 32'h0);
    chk("s4_rst_ctrl", {25'h0, busy0, done0, sel0, a0, b0, c0, d0}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run_sweep(1'b0, 1'b0, 0, 0, 0, lat, fs);
    chk("s4_restart_latency", lat, 320);
    chk("s4_restart_result", res0, 32'hAAAAAAAA);

    // start re-pulsed while busy is ignored
    ymode0 = 2'd0;
    run_sweep(1'b0, 1'b0, 100, 0, 0, lat, fs);
    chk("s5_latency", lat, 320);
    chk("s5_result", res0, 32'hFF00FF00);
    repeat (3) @(negedge clk);
    chk("s5_stays_idle", {31'h0, busy0}, 32'h0);

`ifdef SWEEP_PAUSE_EN
    // pause for 7 cycles mid-sweep delays done by 7
    run_sweep(1'b0, 1'b0, 0, 100, 7, lat, fs);
    chk("s6_latency", lat, 327);
    chk("s6_result", res0, 32'hFF00FF00);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
